// File: rtl/enum_fifo.sv
// Handshaked FIFO for 2-bit E1 enum values with registered head and occupancy.
// Define ENUM_FIFO_ILLEGAL_CHECK_EN to drop 2'b00 writes and report them via err_illegal/drop_cnt.
module enum_fifo #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [1:0]               in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [1:0]               out_data,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     err_illegal,
  input  logic                     err_clear,
  output logic [CNT_W-1:0]         drop_cnt
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  typedef enum logic [1:0] {
    first  = 2'd1,
    second = 2'd2,
    third  = 2'd3
  } e1_t;

  logic [1:0]       mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr_nxt;
  logic [LVL_W-1:0] level_nxt;
  logic             push;
  logic             pop;
  logic             illegal;
  logic             wr_en;

  // in_ready/out_valid are registers, so handshakes depend only on state.
  assign push       = in_valid && in_ready;
  assign pop        = out_valid && out_ready;
  assign wr_en      = push && !illegal;
  assign rd_ptr_nxt = rd_ptr + PTR_W'(1);

  // NOTE: every variable written in always_comb gets a default first so no latch is inferred.
  always_comb begin
    level_nxt = level;
    if (wr_en && !pop)
      level_nxt = level + LVL_W'(1);
    else if (pop && !wr_en)
      level_nxt = level - LVL_W'(1);
  end

  // NOTE: state uses non-blocking assignments; reset is sampled on the clock edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      level     <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_data  <= first;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)   rd_ptr <= rd_ptr_nxt;
      level     <= level_nxt;
      in_ready  <= (level_nxt != LVL_W'(DEPTH));
      out_valid <= (level_nxt != '0);
      // Head register: next entry on pop, incoming value when it lands in an empty slot.
      if (pop) begin
        if (level > LVL_W'(1))
          out_data <= mem[rd_ptr_nxt];
        else if (wr_en)
          out_data <= in_data;
      end else if (wr_en && level == '0) begin
        out_data <= in_data;
      end
    end
  end

  // NOTE: the storage array is deliberately not reset; level and pointers define validity.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= in_data;
  end

`ifdef ENUM_FIFO_ILLEGAL_CHECK_EN
  assign illegal = push && (in_data == 2'b00);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_illegal <= 1'b0;
      drop_cnt    <= '0;
    end else begin
      if (illegal)
        err_illegal <= 1'b1;
      else if (err_clear)
        err_illegal <= 1'b0;
      if (illegal && drop_cnt != '1)
        drop_cnt <= drop_cnt + CNT_W'(1);
    end
  end
`else
  logic unused_err_clear;

  assign illegal          = 1'b0;
  assign err_illegal      = 1'b0;
  assign drop_cnt         = '0;
  assign unused_err_clear = err_clear;
`endif

endmodule

// File: tb/tb_enum_fifo.sv
// Self-checking bench for enum_fifo: queue-based reference model compared every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_enum_fifo;

  localparam int DEPTH = 4;
  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       in_data;
  logic             out_valid;
  logic             out_ready;
  logic [1:0]       out_data;
  logic [2:0]       level;
  logic             err_illegal;
  logic             err_clear;
  logic [CNT_W-1:0] drop_cnt;

  int n_checks = 0;
  int n_errors = 0;

  enum_fifo #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .level       (level),
    .err_illegal (err_illegal),
    .err_clear   (err_clear),
    .drop_cnt    (drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Reference model: a queue of stored values, the last value popped, and the error state.
  logic [1:0] q[$];
  logic [1:0] last_head;
  logic       m_err;
  int         m_drops;
  bit         model_live = 0;
  logic [1:0] rx[$];

  always @(posedge clk) begin
    if (!rst_n) begin
      q.delete();
      last_head  = 2'd1;
      m_err      = 1'b0;
      m_drops    = 0;
      model_live = 1;
    end else if (model_live) begin
      bit acc, take, bad;
      acc  = in_valid && (q.size() != DEPTH);
      take = out_ready && (q.size() != 0);
`ifdef ENUM_FIFO_ILLEGAL_CHECK_EN
      bad  = acc && (in_data == 2'b00);
`else
      bad  = 1'b0;
`endif
      if (take) begin
        last_head = q.pop_front();
        rx.push_back(last_head);
      end
      if (acc && !bad) q.push_back(in_data);
      if (bad) m_err = 1'b1;
      else if (err_clear) m_err = 1'b0;
      if (bad && m_drops < (1 << CNT_W) - 1) m_drops++;
    end
  end

  // Compare process on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (model_live && rst_n) begin
      check("level",       32'(level),       32'(q.size()));
      check("out_valid",   32'(out_valid),   32'(q.size() != 0));
      check("in_ready",    32'(in_ready),    32'(q.size() != DEPTH));
      check("out_data",    32'(out_data),    32'(q.size() != 0 ? q[0] : last_head));
      check("err_illegal", 32'(err_illegal), 32'(m_err));
      check("drop_cnt",    32'(drop_cnt),    32'(m_drops));
    end
  end

  task automatic step(input logic v, input logic [1:0] d, input logic r, input logic clr = 1'b0);
    in_valid  = v;
    in_data   = d;
    out_ready = r;
    err_clear = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic check_rx(input string name, input logic [1:0] exp[$]);
    check({name, "_count"}, 32'(rx.size()), 32'(exp.size()));
    foreach (exp[i]) begin
      if (i < rx.size()) check(name, 32'(rx[i]), 32'(exp[i]));
    end
    rx.delete();
  endtask

  initial begin
    logic [1:0] exp[$];
    rst_n = 1'b0;
    step(1'b0, 2'd0, 1'b0);
    step(1'b0, 2'd0, 1'b0);
    rst_n = 1'b1;
    step(1'b0, 2'd0, 1'b0);

    // Reset then idle.
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready",  32'(in_ready),  32'd1);
    check("rst_level",     32'(level),     32'd0);
    check("rst_out_data",  32'(out_data),  32'd1);
    check("rst_err",       32'(err_illegal), 32'd0);
    rx.delete();

    // Fill to full, refuse a fifth write, drain in order.
    exp = '{2'd1, 2'd2, 2'd3, 2'd1};
    foreach (exp[i]) begin
      step(1'b1, exp[i], 1'b0);
      check("fill_level", 32'(level), 32'(i + 1));
    end
    check("full_in_ready", 32'(in_ready), 32'd0);
    step(1'b1, 2'd2, 1'b0);
    check("fifth_level", 32'(level), 32'd4);
    for (int i = 0; i < 4; i++) step(1'b0, 2'd0, 1'b1);
    check("drained_level", 32'(level), 32'd0);
    check("drained_head",  32'(out_data), 32'd1);
    check_rx("fill_drain", exp);

    // Streaming: both sides ready, pointers wrap several times.
    exp.delete();
    for (int i = 0; i < 16; i++) begin
      exp.push_back((i % 2) ? 2'd3 : 2'd2);
      step(1'b1, exp[i], 1'b1);
      check("stream_level", 32'(level), 32'd1);
    end
    step(1'b0, 2'd0, 1'b1);
    check("stream_empty", 32'(level), 32'd0);
    check_rx("stream", exp);

    // Full FIFO with push and pop requested: pop only, then push accepted.
    exp = '{2'd3, 2'd1, 2'd2, 2'd3};
    foreach (exp[i]) step(1'b1, exp[i], 1'b0);
    step(1'b1, 2'd1, 1'b1);
    check("full_pop_level", 32'(level), 32'd3);
    step(1'b1, 2'd1, 1'b0);
    check("late_push_level", 32'(level), 32'd4);
    for (int i = 0; i < 4; i++) step(1'b0, 2'd0, 1'b1);
    exp = '{2'd3, 2'd1, 2'd2, 2'd3, 2'd1};
    check_rx("full_pop", exp);

    // Illegal encoding handling.
    step(1'b1, 2'd2, 1'b0);
    step(1'b1, 2'd0, 1'b0);
    step(1'b1, 2'd3, 1'b0);
`ifdef ENUM_FIFO_ILLEGAL_CHECK_EN
    check("ill_level", 32'(level), 32'd2);
    check("ill_err",   32'(err_illegal), 32'd1);
    check("ill_drops", 32'(drop_cnt), 32'd1);
    step(1'b1, 2'd0, 1'b0, 1'b1);
    check("ill_set_wins", 32'(err_illegal), 32'd1);
    check("ill_drops2",   32'(drop_cnt), 32'd2);
    step(1'b0, 2'd0, 1'b0, 1'b1);
    check("ill_cleared",  32'(err_illegal), 32'd0);
    check("ill_drops_kept", 32'(drop_cnt), 32'd2);
    for (int i = 0; i < 2; i++) step(1'b0, 2'd0, 1'b1);
    exp = '{2'd2, 2'd3};
`else
    check("ill_level", 32'(level), 32'd3);
    check("ill_err",   32'(err_illegal), 32'd0);
    check("ill_drops", 32'(drop_cnt), 32'd0);
    step(1'b1, 2'd0, 1'b0, 1'b1);
    check("ill_level4", 32'(level), 32'd4);
    for (int i = 0; i < 4; i++) step(1'b0, 2'd0, 1'b1);
    exp = '{2'd2, 2'd0, 2'd3, 2'd0};
`endif
    check_rx("illegal", exp);

    // Reset while holding three entries.
    step(1'b1, 2'd1, 1'b0);
    step(1'b1, 2'd2, 1'b0);
    step(1'b1, 2'd3, 1'b0);
    check("pre_rst_level", 32'(level), 32'd3);
    rst_n = 1'b0;
    step(1'b0, 2'd0, 1'b0);
    rst_n = 1'b1;
    check("mid_rst_level", 32'(level), 32'd0);
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_drops", 32'(drop_cnt), 32'd0);
    check("mid_rst_head",  32'(out_data), 32'd1);
    rx.delete();
    step(1'b1, 2'd2, 1'b0);
    check("post_rst_head", 32'(out_data), 32'd2);
    step(1'b0, 2'd0, 1'b1);
    check("post_rst_level", 32'(level), 32'd0);
    exp = '{2'd2};
    check_rx("post_rst", exp);

    step(1'b0, 2'd0, 1'b0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
